// File: rtl/fir_stream_arbiter.sv
// ---------------------------------------------------------------------------
// fir_stream_arbiter
//
// Frame-granular round-robin arbiter that shares the single FIR input
// AXI-Stream port between two packed IQ sample sources (R in the upper half
// of TDATA, I in the lower half). A grant is held from the first beat of a
// frame to its TLAST. A programmable idle gap follows every frame so the FIR
// pipeline can flush. Frames longer than the programmed maximum are cut
// short: TLAST is forced on the last allowed beat and the rest of the source
// frame is swallowed.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_gap             idle cycles inserted between frames
//   cfg_max_len         maximum beats per frame, 0 = unlimited
//   s0_* / s1_*         the two source streams (tdata/tstrb/tlast/tvalid in,
//                       tready out)
//   m_axis_*            registered stream towards the FIR slave port
//   grant               currently (or most recently) granted source
//   busy                arbiter is not in IDLE
//   trunc_pulse         one-cycle pulse when a frame is truncated
//   frames_done         wrapping count of frames delivered to the FIR
// ---------------------------------------------------------------------------
module fir_stream_arbiter #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int GAP_W                = 16,
  parameter int LEN_W                = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [GAP_W-1:0]                    cfg_gap,
  input  logic [LEN_W-1:0]                    cfg_max_len,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s0_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s0_tstrb,
  input  logic                                s0_tlast,
  input  logic                                s0_tvalid,
  output logic                                s0_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s1_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s1_tstrb,
  input  logic                                s1_tlast,
  input  logic                                s1_tvalid,
  output logic                                s1_tready,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                grant,
  output logic                                busy,
  output logic                                trunc_pulse,
  output logic [15:0]                         frames_done
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int SW = C_S_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_served_q, last_served_d;
  logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0] max_len_q, max_len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]    m_tdata_q, m_tdata_d;
  logic [SW-1:0]    m_tstrb_q, m_tstrb_d;
  logic             m_tlast_q, m_tlast_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             trunc_q, trunc_d;
  logic [15:0]      frames_q, frames_d;

  logic [DW-1:0]    sel_tdata;
  logic [SW-1:0]    sel_tstrb;
  logic             sel_tlast;
  logic             sel_tvalid;
  logic             src_ready;
  logic             accept;
  logic [LEN_W-1:0] beat_nxt;
  logic [GAP_W-1:0] gap_nxt;
  logic             force_last;

  // Granted-source mux and the ready handshake. In SEND the source may only
  // push when the single output register is empty or draining this cycle;
  // in DRAIN the discarded tail is swallowed at full rate.
  always_comb begin
    sel_tdata  = grant_q ? s1_tdata  : s0_tdata;
    sel_tstrb  = grant_q ? s1_tstrb  : s0_tstrb;
    sel_tlast  = grant_q ? s1_tlast  : s0_tlast;
    sel_tvalid = grant_q ? s1_tvalid : s0_tvalid;
    case (state_q)
      SEND:    src_ready = !m_tvalid_q || m_axis_tready;
      DRAIN:   src_ready = 1'b1;
      default: src_ready = 1'b0;
    endcase
    s0_tready  = src_ready && !grant_q;
    s1_tready  = src_ready && grant_q;
    accept     = sel_tvalid && src_ready;
    beat_nxt   = beat_cnt_q + 1'b1;
    gap_nxt    = gap_cnt_q + 1'b1;
    force_last = (max_len_q != '0) && (beat_nxt == max_len_q);
  end

  // Next-state logic for the arbiter FSM, the output register and the
  // frame counter. Frame completion skips GAP entirely when the latched gap
  // is zero so back-to-back frames only pay the single IDLE cycle.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    gap_lat_d     = gap_lat_q;
    gap_cnt_d     = gap_cnt_q;
    max_len_d     = max_len_q;
    beat_cnt_d    = beat_cnt_q;
    m_tdata_d     = m_tdata_q;
    m_tstrb_d     = m_tstrb_q;
    m_tlast_d     = m_tlast_q;
    m_tvalid_d    = m_tvalid_q;
    trunc_d       = 1'b0;
    frames_d      = frames_q;

    if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
    if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
      frames_d = frames_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          grant_d    = (s0_tvalid && s1_tvalid) ? !last_served_q : s1_tvalid;
          state_d    = SEND;
          gap_lat_d  = cfg_gap;
          max_len_d  = cfg_max_len;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
        end
      end
      SEND: begin
        if (accept) begin
          m_tdata_d  = sel_tdata;
          m_tstrb_d  = sel_tstrb;
          m_tlast_d  = sel_tlast || force_last;
          m_tvalid_d = 1'b1;
          beat_cnt_d = beat_nxt;
          if (sel_tlast) begin
            last_served_d = grant_q;
            gap_cnt_d     = '0;
            state_d       = (gap_lat_q == '0) ? IDLE : GAP;
          end else if (force_last) begin
            trunc_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && sel_tlast) begin
          last_served_d = grant_q;
          gap_cnt_d     = '0;
          state_d       = (gap_lat_q == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_nxt;
        if (gap_nxt == gap_lat_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state is registered here. last_served resets to 1 so that source 0
  // wins the first contested arbitration after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
      gap_lat_q     <= '0;
      gap_cnt_q     <= '0;
      max_len_q     <= '0;
      beat_cnt_q    <= '0;
      m_tdata_q     <= '0;
      m_tstrb_q     <= '0;
      m_tlast_q     <= 1'b0;
      m_tvalid_q    <= 1'b0;
      trunc_q       <= 1'b0;
      frames_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      gap_lat_q     <= gap_lat_d;
      gap_cnt_q     <= gap_cnt_d;
      max_len_q     <= max_len_d;
      beat_cnt_q    <= beat_cnt_d;
      m_tdata_q     <= m_tdata_d;
      m_tstrb_q     <= m_tstrb_d;
      m_tlast_q     <= m_tlast_d;
      m_tvalid_q    <= m_tvalid_d;
      trunc_q       <= trunc_d;
      frames_q      <= frames_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);
  assign trunc_pulse   = trunc_q;
  assign frames_done   = frames_q;

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_arbiter
//
// Directed bench for fir_stream_arbiter. Each scenario pushes the beats it
// expects the FIR side to see into a scoreboard queue; an independent
// monitor pops and compares on every output handshake. Side monitors watch
// accept-to-output latency, the inter-frame gap, stall stability and
// truncation pulses while their scenario is active.
// ---------------------------------------------------------------------------
module tb_fir_stream_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_gap;
  logic [15:0] cfg_max_len;
  logic [31:0] s0_tdata;
  logic [3:0]  s0_tstrb;
  logic        s0_tlast;
  logic        s0_tvalid;
  logic        s0_tready;
  logic [31:0] s1_tdata;
  logic [3:0]  s1_tstrb;
  logic        s1_tlast;
  logic        s1_tvalid;
  logic        s1_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        grant;
  logic        busy;
  logic        trunc_pulse;
  logic [15:0] frames_done;

  int testsRun  = 0;
  int failCount = 0;
  int cycle     = 0;
  int expFrames = 0;
  int truncCount = 0;

  logic [63:0] expQ[$];

  bit latChk  = 0;
  bit accPrev = 0;
  bit gapChk  = 0;
  bit havePrev = 0;
  int prevCyc = 0;
  int gapChecks = 0;
  bit stabChk = 0;
  bit prevStall = 0;
  logic [63:0] prevWord = '0;
  bit bpOn = 0;

  fir_stream_arbiter #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .GAP_W(16),
    .LEN_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_gap      (cfg_gap),
    .cfg_max_len  (cfg_max_len),
    .s0_tdata     (s0_tdata),
    .s0_tstrb     (s0_tstrb),
    .s0_tlast     (s0_tlast),
    .s0_tvalid    (s0_tvalid),
    .s0_tready    (s0_tready),
    .s1_tdata     (s1_tdata),
    .s1_tstrb     (s1_tstrb),
    .s1_tlast     (s1_tlast),
    .s1_tvalid    (s1_tvalid),
    .s1_tready    (s1_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .grant        (grant),
    .busy         (busy),
    .trunc_pulse  (trunc_pulse),
    .frames_done  (frames_done)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Beat encoding: R = running beat value, I = source index.
  function automatic logic [31:0] beatData(input int src, input int val);
    beatData = {16'(val), 16'(src)};
  endfunction

  function automatic logic [3:0] beatStrb(input int val);
    beatStrb = 4'(val) | 4'b0001;
  endfunction

  function automatic logic [63:0] packOut();
    packOut = {5'b0, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb,
               s0_tready, s1_tready, grant, busy, trunc_pulse, frames_done};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int src, input int val, input bit last);
    expQ.push_back({27'b0, last, beatStrb(val), beatData(src, val)});
  endtask

  // Drives one frame on a source. Beat b carries value base+b and TLAST on
  // beat lastAt. stopAfter>0 abandons the frame after that many accepts.
  task automatic applyStimulus(input int src, input int nBeats, input int base,
                               input int lastAt, input int stopAfter);
    int guard;
    bit rdy;
    for (int b = 1; b <= nBeats; b++) begin
      if (src == 0) begin
        s0_tdata = beatData(0, base + b); s0_tstrb = beatStrb(base + b);
        s0_tlast = (b == lastAt); s0_tvalid = 1'b1;
      end else begin
        s1_tdata = beatData(1, base + b); s1_tstrb = beatStrb(base + b);
        s1_tlast = (b == lastAt); s1_tvalid = 1'b1;
      end
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
        rdy = (src == 0) ? s0_tready : s1_tready;
      end while (!rdy && guard < 2000);
      if (!rdy) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL src%0d_ready_timeout: ready stayed 0, required 1 (beat %0d)", src, b);
        break;
      end
      @(posedge clk);
      #1;
      if (stopAfter == b) break;
    end
    if (src == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    else begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output handshake must match the oldest
  // expected beat.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat_sb_size", 64'(expQ.size()), 64'd1);
      end else begin
        exp = expQ.pop_front();
        checkOutput("beat", {27'b0, m_axis_tlast, m_axis_tstrb, m_axis_tdata}, exp);
      end
    end
  end

  // Side monitors: cycle count, truncation pulses, output latency, the
  // source-accept spacing across a frame boundary, and stall stability.
  always @(negedge clk) begin
    bit accNow;
    cycle++;
    accNow = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);
    if (!rst && trunc_pulse) truncCount++;
    if (latChk) checkOutput("accept_latency", 64'(m_axis_tvalid), 64'(accPrev));
    accPrev = accNow;
    if (gapChk && accNow) begin
      if (havePrev) begin
        checkOutput("gap_spacing", 64'(cycle - prevCyc), 64'd7);
        gapChecks++;
        havePrev = 0;
      end
      if ((s0_tvalid && s0_tready && s0_tlast) || (s1_tvalid && s1_tready && s1_tlast)) begin
        prevCyc  = cycle;
        havePrev = 1;
      end
    end
    if (stabChk) begin
      if (prevStall) checkOutput("stall_hold", {27'b0, m_axis_tvalid, m_axis_tstrb, m_axis_tdata}, prevWord);
      if (m_axis_tvalid && !m_axis_tready) checkOutput("s0_ready_while_full", 64'(s0_tready), 64'd0);
    end
    prevStall = m_axis_tvalid && !m_axis_tready;
    prevWord  = {27'b0, m_axis_tvalid, m_axis_tstrb, m_axis_tdata};
  end

  initial begin
    bit bpPat[4];
    bpPat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    cfg_gap = 16'd0; cfg_max_len = 16'd0;
    s0_tdata = '0; s0_tstrb = '0; s0_tlast = 1'b0; s0_tvalid = 1'b0;
    s1_tdata = '0; s1_tstrb = '0; s1_tlast = 1'b0; s1_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    settle(2);
    checkOutput("reset_state", packOut(), 64'd0);
    rst = 1'b0;
    settle(1);

    // Single source, 4 beats (1,0)..(4,0), no gap, no length cap.
    for (int b = 1; b <= 4; b++) pushExp(0, b, b == 4);
    latChk = 1;
    applyStimulus(0, 4, 0, 4, 0);
    settle(3);
    latChk = 0;
    expFrames = 1;
    checkOutput("t1_frames_done", 64'(frames_done), 64'(expFrames));
    checkOutput("t1_sb_empty", 64'(expQ.size()), 64'd0);
    checkOutput("t1_grant", 64'(grant), 64'd0);

    // Truncation: s1 frame of 12 beats capped at 8.
    cfg_max_len = 16'd8;
    for (int b = 1; b <= 8; b++) pushExp(1, 100 + b, b == 8);
    applyStimulus(1, 12, 100, 12, 0);
    settle(3);
    expFrames = 2;
    checkOutput("t3_frames_done", 64'(frames_done), 64'(expFrames));
    checkOutput("t3_trunc_count", 64'(truncCount), 64'd1);
    checkOutput("t3_sb_empty", 64'(expQ.size()), 64'd0);
    checkOutput("t3_grant", 64'(grant), 64'd1);
    checkOutput("t3_idle", 64'(busy), 64'd0);

    // Both sources valid, 3-beat frames, gap 5: grant order 0,1,0,1.
    cfg_max_len = 16'd0;
    cfg_gap = 16'd5;
    for (int b = 1; b <= 3; b++) pushExp(0, 10 + b, b == 3);
    for (int b = 1; b <= 3; b++) pushExp(1, 20 + b, b == 3);
    for (int b = 1; b <= 3; b++) pushExp(0, 30 + b, b == 3);
    for (int b = 1; b <= 3; b++) pushExp(1, 40 + b, b == 3);
    havePrev = 0; gapChecks = 0; gapChk = 1;
    fork
      begin applyStimulus(0, 3, 10, 3, 0); applyStimulus(0, 3, 30, 3, 0); end
      begin applyStimulus(1, 3, 20, 3, 0); applyStimulus(1, 3, 40, 3, 0); end
    join
    settle(8);
    gapChk = 0;
    expFrames = 6;
    checkOutput("t2_frames_done", 64'(frames_done), 64'(expFrames));
    checkOutput("t2_gap_checks", 64'(gapChecks), 64'd3);
    checkOutput("t2_sb_empty", 64'(expQ.size()), 64'd0);

    // Backpressure: tready pattern 1,0,0,1 during a 6-beat s0 frame.
    cfg_gap = 16'd1;
    for (int b = 1; b <= 6; b++) pushExp(0, 50 + b, b == 6);
    stabChk = 1; bpOn = 1;
    fork
      begin applyStimulus(0, 6, 50, 6, 0); bpOn = 0; end
      begin
        int i;
        i = 0;
        while (bpOn) begin
          @(posedge clk);
          #1;
          m_axis_tready = bpPat[i % 4];
          i++;
        end
      end
    join
    repeat (6) begin
      @(posedge clk); #1; m_axis_tready = (m_axis_tready == 1'b0);
    end
    m_axis_tready = 1'b1;
    settle(4);
    stabChk = 0;
    expFrames = 7;
    checkOutput("t4_frames_done", 64'(frames_done), 64'(expFrames));
    checkOutput("t4_sb_empty", 64'(expQ.size()), 64'd0);

    // Reset after beat 3 of a 10-beat frame; only beats 1-2 reach the FIR.
    cfg_gap = 16'd2;
    pushExp(0, 61, 1'b0);
    pushExp(0, 62, 1'b0);
    applyStimulus(0, 10, 60, 10, 3);
    #1 rst = 1'b1;
    #1 checkOutput("t5_async_reset_outputs", packOut(), 64'd0);
    checkOutput("t5_sb_empty_at_reset", 64'(expQ.size()), 64'd0);
    expFrames = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    for (int b = 1; b <= 3; b++) pushExp(0, 200 + b, b == 3);
    for (int b = 1; b <= 3; b++) pushExp(1, 210 + b, b == 3);
    fork
      applyStimulus(0, 3, 200, 3, 0);
      applyStimulus(1, 3, 210, 3, 0);
    join
    settle(6);
    expFrames = 2;
    checkOutput("t5_frames_done", 64'(frames_done), 64'(expFrames));
    checkOutput("t5_sb_empty", 64'(expQ.size()), 64'd0);

    // Length cap equal to the natural frame length: normal completion.
    cfg_gap = 16'd0;
    cfg_max_len = 16'd5;
    for (int b = 1; b <= 5; b++) pushExp(0, 80 + b, b == 5);
    applyStimulus(0, 5, 80, 5, 0);
    settle(3);
    expFrames = 3;
    checkOutput("t6_frames_done", 64'(frames_done), 64'(expFrames));
    checkOutput("t6_trunc_count", 64'(truncCount), 64'd1);
    checkOutput("t6_sb_empty", 64'(expQ.size()), 64'd0);
    checkOutput("t6_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
